mux16_scan_ctrl: RTL and testbench

//  Upstream sequencer for the 8-bit 16:1 channel mux; drives its 4-bit select and captures its output.

---
 rtl/mux16_scan_ctrl_pkg.sv | 13 +
 rtl/mux16_scan_ctrl_if.sv | 37 +++
 rtl/mux16_scan_ctrl_dwell_timer.sv | 28 ++
 rtl/mux16_scan_ctrl.sv | 128 ++++++++++++
 tb/tb_mux16_scan_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mux16_scan_ctrl_pkg.sv
// Shared types and constants for the 16:1 mux scan controller.
package mux_scan_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEEK   = 2'd1,
        SETTLE = 2'd2,
        HOLD   = 2'd3
    } scan_state_t;

    localparam int              NCH     = 16;
    localparam int              SEL_W   = 4;
    localparam logic [SEL_W-1:0] LAST_CH = 4'd15;
endpackage

// File: rtl/mux16_scan_ctrl_if.sv
// Handshake/bus bundle between the scan controller, the external mux and the downstream stage.
// Under MUX_SCAN_CONT_EN the bundle also carries the cont request.
interface mux16_scan_ctrl_if
    import mux_scan_pkg::*;
#(
    parameter int WIDTH = 8
);
`ifdef MUX_SCAN_CONT_EN
    logic             cont;
`endif
    logic             start;
    logic [NCH-1:0]   mask;
    logic [WIDTH-1:0] mux_o;
    logic [SEL_W-1:0] select;
    logic [WIDTH-1:0] data_out;
    logic [SEL_W-1:0] chan_out;
    logic             valid;
    logic             ready;
    logic             busy;
    logic             done;

    modport master (
`ifdef MUX_SCAN_CONT_EN
        output cont,
`endif
        output start, mask, mux_o, ready,
        input  select, data_out, chan_out, valid, busy, done
    );

    modport slave (
`ifdef MUX_SCAN_CONT_EN
        input  cont,
`endif
        input  start, mask, mux_o, ready,
        output select, data_out, chan_out, valid, busy, done
    );
endinterface

// File: rtl/mux16_scan_ctrl_dwell_timer.sv
// 8-bit load/decrement settle counter with a zero flag.
module dwell_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic [7:0] val_i,
    input  logic       dec_i,
    output logic       zero_o
);
    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = val_i;
        else if (dec_i && (cnt_q != 8'd0))
            cnt_d = cnt_q - 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= 8'd0;
        else
            cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == 8'd0);
endmodule

// File: rtl/mux16_scan_ctrl.sv
// Sequencer for an external 16:1 mux: walks enabled channels, dwells, captures, hands off on valid/ready.
// Define MUX_SCAN_CONT_EN to add the cont input for back-to-back continuous passes.
module mux16_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DWELL = 4
) (
    input logic              clk,
    input logic              rst,
    mux16_scan_ctrl_if.slave bus
);
    localparam logic [7:0] DWELL_LD = 8'(DWELL - 1);

    scan_state_t      state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] chan_q, chan_d;
    logic [NCH-1:0]   mask_q, mask_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
    logic             tmr_load, tmr_dec, tmr_zero;
    logic             end_pass;

    dwell_timer u_timer (
        .clk    (clk),
        .rst    (rst),
        .load_i (tmr_load),
        .val_i  (DWELL_LD),
        .dec_i  (tmr_dec),
        .zero_o (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            chan_q  <= '0;
            mask_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            chan_q  <= chan_d;
            mask_q  <= mask_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        chan_d   = chan_q;
        mask_d   = mask_q;
        data_d   = data_q;
        valid_d  = valid_q;
        done_d   = 1'b0;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        end_pass = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mask_d  = bus.mask;
                    sel_d   = '0;
                    state_d = SEEK;
                end
            end
            SEEK: begin
                if (mask_q[sel_q]) begin
                    tmr_load = 1'b1;
                    state_d  = SETTLE;
                end else if (sel_q == LAST_CH) begin
                    end_pass = 1'b1;
                end else begin
                    sel_d = sel_q + SEL_W'(1);
                end
            end
            SETTLE: begin
                if (tmr_zero) begin
                    data_d  = bus.mux_o;
                    chan_d  = sel_q;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            HOLD: begin
                // valid is always set while in HOLD, so ready alone completes the transfer
                if (bus.ready) begin
                    valid_d = 1'b0;
                    if (sel_q == LAST_CH) begin
                        end_pass = 1'b1;
                    end else begin
                        sel_d   = sel_q + SEL_W'(1);
                        state_d = SEEK;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (end_pass) begin
            done_d  = 1'b1;
            state_d = IDLE;
`ifdef MUX_SCAN_CONT_EN
            if (bus.cont) begin
                sel_d   = '0;
                mask_d  = bus.mask;
                state_d = SEEK;
            end
`endif
        end
    end

    assign bus.select   = sel_q;
    assign bus.data_out = data_q;
    assign bus.chan_out = chan_q;
    assign bus.valid    = valid_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;
endmodule

// File: tb/tb_mux16_scan_ctrl.sv
// Self-checking bench for mux16_scan_ctrl: vector table, corner-case sequences and randomized scans.
module tb_mux16_scan_ctrl;
    localparam int W  = 8;
    localparam int DW = 4;

    typedef struct {
        int         ch;
        logic [7:0] d;
        int         cyc;
    } xfer_t;

    typedef struct {
        logic [15:0] mask;
        int          n;
        int          fv_lat;
        int          done_lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mux16_scan_ctrl_if #(.WIDTH(W)) bus ();

    mux16_scan_ctrl #(.WIDTH(W), .DWELL(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] ch_val [16];
    assign bus.mux_o = ch_val[bus.select];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor samples on the falling edge; inputs change 1 time unit after the rising edge.
    xfer_t      got_q[$];
    int         done_cnt = 0;
    int         done_cyc = -1;
    int         fv_cyc   = -1;
    logic       p_hold   = 1'b0;
    logic [7:0] p_d;
    logic [3:0] p_c, p_s;

    always @(negedge clk) begin
        if (p_hold) begin
            chk("hold_valid", 32'(bus.valid), 1);
            chk("hold_data", 32'(bus.data_out), 32'(p_d));
            chk("hold_chan", 32'(bus.chan_out), 32'(p_c));
            chk("hold_sel", 32'(bus.select), 32'(p_s));
        end
        if (!rst) begin
            if (bus.valid && bus.ready) got_q.push_back('{int'(bus.chan_out), bus.data_out, cyc});
            if (bus.valid && fv_cyc < 0) fv_cyc = cyc;
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
        p_hold = bus.valid && !bus.ready && !rst;
        p_d    = bus.data_out;
        p_c    = bus.chan_out;
        p_s    = bus.select;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        got_q.delete();
        done_cnt = 0;
        done_cyc = -1;
        fv_cyc   = -1;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (done_cnt > 0) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    // Reference: every enabled channel, ascending, carrying that channel's mux value.
    task automatic check_xfers(input logic [15:0] m);
        int n = 0;
        for (int c = 0; c < 16; c++) begin
            if (m[c]) begin
                if (n < got_q.size()) begin
                    chk("xfer_chan", got_q[n].ch, c);
                    chk("xfer_data", 32'(got_q[n].d), 32'(ch_val[c]));
                end
                n++;
            end
        end
        chk("xfer_count", got_q.size(), n);
    endtask

    task automatic run_scan(input logic [15:0] m, input bit rnd, output int t0);
        bit ok;
        clear_mon();
        bus.mask  = m;
        bus.start = 1'b1;
        if (!rnd) bus.ready = 1'b1;
        t0 = cyc;
        step();
        bus.start = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 600; k++) begin
            if (done_cnt > 0) begin
                ok = 1'b1;
                break;
            end
            if (rnd) begin
                bus.ready = 1'($urandom_range(0, 1));
                bus.mask  = 16'($urandom);
            end
            step();
        end
        chk("done_seen", 32'(ok), 1);
        repeat (3) step();
        chk("done_once", done_cnt, 1);
        chk("idle_busy", 32'(bus.busy), 0);
    endtask

    vec_t tbl[5];

    initial begin
        int  t0;
        bit  ok;
        logic [15:0] m;

        for (int i = 0; i < 16; i++) ch_val[i] = 8'(8'h40 + i);
        ch_val[0]  = 8'h00;
        ch_val[1]  = 8'h81;
        ch_val[2]  = 8'h02;
        ch_val[15] = 8'h93;

        // done latency with ready held high: 16 SEEK cycles + 1, plus DWELL+1 per enabled channel
        tbl[0] = '{16'h0001, 1,  6, 22};
        tbl[1] = '{16'h8006, 3,  7, 32};
        tbl[2] = '{16'h0000, 0, -1, 17};
        tbl[3] = '{16'hFFFF, 16, 6, 97};
        tbl[4] = '{16'h8000, 1, 21, 22};

        bus.start = 1'b0;
        bus.mask  = '0;
        bus.ready = 1'b0;
`ifdef MUX_SCAN_CONT_EN
        bus.cont  = 1'b0;
`endif

        rst = 1'b1;
        repeat (2) step();
        chk("rst_select", 32'(bus.select), 0);
        chk("rst_valid", 32'(bus.valid), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_data", 32'(bus.data_out), 0);
        chk("rst_chan", 32'(bus.chan_out), 0);
        rst = 1'b0;
        step();

        for (int v = 0; v < 5; v++) begin
            run_scan(tbl[v].mask, 1'b0, t0);
            check_xfers(tbl[v].mask);
            chk("vec_n", got_q.size(), tbl[v].n);
            chk("vec_first_valid", (fv_cyc < 0) ? -1 : fv_cyc - t0, tbl[v].fv_lat);
            chk("vec_done_lat", done_cyc - t0, tbl[v].done_lat);
        end

        // Backpressure: hold for 10 cycles, then release.
        clear_mon();
        bus.ready = 1'b0;
        bus.mask  = 16'h0004;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (bus.valid) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        chk("bp_valid_seen", 32'(ok), 1);
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", 32'(bus.valid), 1);
            chk("bp_data", 32'(bus.data_out), 32'h02);
            chk("bp_chan", 32'(bus.chan_out), 2);
            chk("bp_select", 32'(bus.select), 2);
            step();
        end
        chk("bp_no_xfer", got_q.size(), 0);
        bus.ready = 1'b1;
        step();
        chk("bp_xfer", got_q.size(), 1);
        chk("bp_valid_drop", 32'(bus.valid), 0);
        wait_done(40, ok);
        chk("bp_done", 32'(ok), 1);
        check_xfers(16'h0004);

        // Start pulse while busy must be dropped, not queued.
        clear_mon();
        bus.mask  = 16'h0000;
        bus.start = 1'b1;
        t0 = cyc;
        step();
        bus.start = 1'b0;
        repeat (4) step();
        bus.mask  = 16'hFFFF;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        wait_done(40, ok);
        chk("busy_start_done", 32'(ok), 1);
        chk("busy_start_lat", done_cyc - t0, 17);
        repeat (4) step();
        chk("busy_start_dropped", 32'(bus.busy), 0);
        chk("busy_start_novalid", fv_cyc, -1);
        chk("busy_start_done_once", done_cnt, 1);

        // Reset while holding a valid word.
        clear_mon();
        bus.ready = 1'b0;
        bus.mask  = 16'h0001;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (bus.valid) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        chk("rsthold_valid_seen", 32'(ok), 1);
        rst = 1'b1;
        step();
        chk("rsthold_valid", 32'(bus.valid), 0);
        chk("rsthold_busy", 32'(bus.busy), 0);
        chk("rsthold_select", 32'(bus.select), 0);
        rst = 1'b0;
        repeat (5) step();
        chk("rsthold_no_done", done_cnt, 0);
        chk("rsthold_idle", 32'(bus.busy), 0);
        bus.ready = 1'b1;

        // Randomized passes: even ones with ready high also check the cycle count.
        for (int it = 0; it < 20; it++) begin
            m = 16'($urandom);
            if (it % 5 == 0) m = m & 16'($urandom);
            run_scan(m, (it % 2) == 1, t0);
            check_xfers(m);
            if ((it % 2) == 0) chk("rnd_done_lat", done_cyc - t0, 17 + $countones(m) * (DW + 1));
        end
        bus.ready = 1'b1;

`ifdef MUX_SCAN_CONT_EN
        clear_mon();
        bus.cont  = 1'b1;
        bus.mask  = 16'h8001;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (got_q.size() >= 3) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        chk("cont_three_xfers", 32'(ok), 1);
        if (got_q.size() >= 3) begin
            chk("cont_x0", got_q[0].ch, 0);
            chk("cont_x1", got_q[1].ch, 15);
            chk("cont_wrap", got_q[2].ch, 0);
        end
        chk("cont_done_pulsed", 32'(done_cnt >= 1), 1);
        chk("cont_still_busy", 32'(bus.busy), 1);
        bus.cont = 1'b0;
        t0 = done_cnt;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (done_cnt > t0) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        chk("cont_stop", 32'(ok), 1);
        repeat (3) step();
        chk("cont_idle", 32'(bus.busy), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish (errors=%0d)", errors);
        $fatal(1);
    end
endmodule
